// File: rtl/profile_seq.sv
// profile_seq: descriptor sequencer that writes profile_gen parameters and paces acc_step strobes.
// Optional build macro PSEQ_CLEAR_ON_IDLE_EN adds a CLEAR pass writing zeros before returning to IDLE.
module profile_seq #(
   parameter logic [7:0] ADDR0 = 8'h00,
   parameter logic [7:0] ADDR1 = 8'h03,
   parameter logic [7:0] ADDR2 = 8'h04,
   parameter logic [7:0] ADDR3 = 8'h05
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seg_valid,
   output logic        seg_ready,
   input  logic [31:0] seg_p0,
   input  logic [31:0] seg_p1,
   input  logic [31:0] seg_p2,
   input  logic [31:0] seg_p3,
   input  logic [15:0] seg_period,
   input  logic [31:0] seg_dur,
   input  logic        abort,
   output logic [7:0]  param_addr,
   output logic [31:0] param_in,
   output logic        param_write_lo,
   output logic        param_write_hi,
   output logic        acc_step,
   output logic        busy,
   output logic        seg_done,
   output logic        underrun
);

`ifdef PSEQ_CLEAR_ON_IDLE_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CLEAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

   typedef struct packed {
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] p3;
      logic [15:0] period;
      logic [31:0] dur;
   } desc_t;

   state_t      state, state_nx;
   desc_t       act_q, pend_q, seg_in;
   logic        pend_full;
   logic [2:0]  k_q;
   logic [15:0] pcnt_q;
   logic [15:0] per_eff;
   logic [31:0] step_q;
   logic        underrun_q;

   logic        accept, seq_last, seg_end, in_seq;
   logic        act_ld_in, act_ld_pend, pend_ld, pend_clr, ur_set, ur_clr;
   logic [7:0]  sel_addr;
   logic [31:0] sel_word;

   assign seg_in    = '{p0: seg_p0, p1: seg_p1, p2: seg_p2, p3: seg_p3,
                        period: seg_period, dur: seg_dur};
   assign seg_ready = !pend_full && !abort;
   assign accept    = seg_valid && seg_ready;
   assign seq_last  = (k_q == 3'd7);
   assign seg_end   = (state == S_RUN) && (step_q == act_q.dur);
   assign per_eff   = (act_q.period == 16'd0) ? 16'd1 : act_q.period;
   assign busy      = (state != S_IDLE);
   assign seg_done  = seg_end && !abort;
   assign acc_step  = (state == S_RUN) && (pcnt_q == 16'd0) && (step_q != act_q.dur);
   assign underrun  = underrun_q;

`ifdef PSEQ_CLEAR_ON_IDLE_EN
   assign in_seq = (state == S_LOAD) || (state == S_CLEAR);
`else
   assign in_seq = (state == S_LOAD);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      act_ld_in   = 1'b0;
      act_ld_pend = 1'b0;
      pend_ld     = 1'b0;
      pend_clr    = 1'b0;
      ur_set      = 1'b0;
      ur_clr      = 1'b0;
      if (abort) begin
         state_nx = S_IDLE;
         pend_clr = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  act_ld_in = 1'b1;
                  ur_clr    = 1'b1;
                  state_nx  = S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) pend_ld = 1'b1;
               if (seq_last) state_nx = S_RUN;
            end
            S_RUN: begin
               // A descriptor arriving exactly at segment end bypasses pending.
               if (seg_end) begin
                  if (pend_full) begin
                     act_ld_pend = 1'b1;
                     pend_clr    = 1'b1;
                     state_nx    = S_LOAD;
                  end else if (accept) begin
                     act_ld_in = 1'b1;
                     state_nx  = S_LOAD;
                  end else begin
                     ur_set = 1'b1;
`ifdef PSEQ_CLEAR_ON_IDLE_EN
                     state_nx = S_CLEAR;
`else
                     state_nx = S_IDLE;
`endif
                  end
               end else if (accept) begin
                  pend_ld = 1'b1;
               end
            end
`ifdef PSEQ_CLEAR_ON_IDLE_EN
            S_CLEAR: begin
               if (seq_last) begin
                  if (pend_full) begin
                     act_ld_pend = 1'b1;
                     pend_clr    = 1'b1;
                     state_nx    = S_LOAD;
                  end else if (accept) begin
                     act_ld_in = 1'b1;
                     state_nx  = S_LOAD;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else if (accept) begin
                  pend_ld = 1'b1;
               end
            end
`endif
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q      <= '0;
         pend_q     <= '0;
         pend_full  <= 1'b0;
         underrun_q <= 1'b0;
         k_q        <= '0;
         pcnt_q     <= '0;
         step_q     <= '0;
      end else begin
         if (act_ld_in)        act_q <= seg_in;
         else if (act_ld_pend) act_q <= pend_q;

         if (pend_clr) begin
            pend_full <= 1'b0;
         end else if (pend_ld) begin
            pend_q    <= seg_in;
            pend_full <= 1'b1;
         end

         if (ur_clr)      underrun_q <= 1'b0;
         else if (ur_set) underrun_q <= 1'b1;

         k_q <= in_seq ? k_q + 3'd1 : '0;

         // Counter preloads outside RUN so the first strobe lands period cycles after entry.
         if (state != S_RUN)       pcnt_q <= per_eff;
         else if (pcnt_q == 16'd0) pcnt_q <= per_eff - 16'd1;
         else                      pcnt_q <= pcnt_q - 16'd1;

         if (state != S_RUN) step_q <= '0;
         else if (acc_step)  step_q <= step_q + 32'd1;
      end
   end

   always_comb begin
      sel_addr = ADDR0;
      sel_word = act_q.p0;
      case (k_q[2:1])
         2'd0: begin sel_addr = ADDR0; sel_word = act_q.p0; end
         2'd1: begin sel_addr = ADDR1; sel_word = act_q.p1; end
         2'd2: begin sel_addr = ADDR2; sel_word = act_q.p2; end
         default: begin sel_addr = ADDR3; sel_word = act_q.p3; end
      endcase
   end

   always_comb begin
      param_addr     = '0;
      param_in       = '0;
      param_write_lo = 1'b0;
      param_write_hi = 1'b0;
      if (in_seq) begin
         param_addr     = sel_addr;
         param_write_lo = !k_q[0];
         param_write_hi = k_q[0];
         if (state == S_LOAD) param_in = k_q[0] ? {32{sel_word[31]}} : sel_word;
      end
   end

endmodule

// File: tb/tb_profile_seq.sv
// Self-checking bench for profile_seq: table of single-segment scenarios plus
// hand sequences for back-to-back, same-cycle handoff, abort and async reset.
module tb_profile_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seg_valid = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] seg_p0 = '0, seg_p1 = '0, seg_p2 = '0, seg_p3 = '0;
   logic [15:0] seg_period = '0;
   logic [31:0] seg_dur = '0;
   logic        seg_ready;
   logic [7:0]  param_addr;
   logic [31:0] param_in;
   logic        param_write_lo, param_write_hi, acc_step, busy, seg_done, underrun;

   always #5 clk = ~clk;

   profile_seq dut (
      .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_p0(seg_p0), .seg_p1(seg_p1), .seg_p2(seg_p2), .seg_p3(seg_p3),
      .seg_period(seg_period), .seg_dur(seg_dur), .abort(abort),
      .param_addr(param_addr), .param_in(param_in),
      .param_write_lo(param_write_lo), .param_write_hi(param_write_hi),
      .acc_step(acc_step), .busy(busy), .seg_done(seg_done), .underrun(underrun)
   );

   typedef struct {
      logic [31:0]      p0, p1, p2, p3;
      logic [15:0]      period;
      logic [31:0]      dur;
      logic [0:7][31:0] w;
      int               first, gap, nsteps, done;
   } sc_t;

   sc_t         sc [4];
   logic [7:0]  beat_addr [8];
   logic [41:0] beats [$];
   int          steps [$];
   int          checks = 0;
   int          errors = 0;
   int          done_off;
   int          cnt;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, b, c, d, input logic [15:0] per, input logic [31:0] dur);
      seg_valid = 1'b1; seg_p0 = a; seg_p1 = b; seg_p2 = c; seg_p3 = d;
      seg_period = per; seg_dur = dur;
   endtask

   function automatic sc_t mk(input logic [31:0] a, b, c, d, input logic [15:0] per,
                              input logic [31:0] dur, input logic [0:7][31:0] w,
                              input int first, gap, n, done);
      sc_t s;
      s.p0 = a; s.p1 = b; s.p2 = c; s.p3 = d; s.period = per; s.dur = dur; s.w = w;
      s.first = first; s.gap = gap; s.nsteps = n; s.done = done;
      return s;
   endfunction

   initial begin
      beat_addr = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
      // Offsets count cycles after the accepting edge: LOAD is 1..8, RUN entry is 9.
      sc[0] = mk(32'd1, 32'd3, 32'd4, 32'd5, 16'd100, 32'd3,
                 {32'd1, 32'd0, 32'd3, 32'd0, 32'd4, 32'd0, 32'd5, 32'd0}, 109, 100, 3, 310);
      sc[1] = mk(32'd0, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 16'd0, 32'd4,
                 {32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h7FFF_FFFF, 32'd0}, 10, 1, 4, 14);
      sc[2] = mk(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFF9, 16'd1, 32'd0,
                 {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0,
                  32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0, 0, 0, 9);
      sc[3] = mk(32'd7, 32'd8, 32'd9, 32'd10, 16'd3, 32'd2,
                 {32'd7, 32'd0, 32'd8, 32'd0, 32'd9, 32'd0, 32'd10, 32'd0}, 12, 3, 2, 16);

      // Reset state
      #3;
      check("reset_outputs", {param_addr, param_in, param_write_lo, param_write_hi,
                              acc_step, busy, seg_done, underrun}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      cyc(); #1;
      check("ready_after_reset", seg_ready, 1);

      // Table-driven single segments
      for (int s = 0; s < 4; s++) begin
         cyc();
         drive(sc[s].p0, sc[s].p1, sc[s].p2, sc[s].p3, sc[s].period, sc[s].dur);
         #1;
         check("ready_idle", seg_ready, 1);
         cyc(); seg_valid = 1'b0; #1;
         beats.delete(); steps.delete(); done_off = -1;
         for (int off = 1; off <= 400; off++) begin
            if (off > 1) begin cyc(); #1; end
            if (param_write_lo || param_write_hi)
               beats.push_back({param_addr, param_in, param_write_lo, param_write_hi});
            if (acc_step) steps.push_back(off);
            if (seg_done) begin done_off = off; break; end
         end
         check($sformatf("s%0d_done_cycle", s), done_off, sc[s].done);
         check($sformatf("s%0d_nbeats", s), beats.size(), 8);
         for (int i = 0; i < 8 && i < beats.size(); i++)
            check($sformatf("s%0d_beat%0d", s, i), beats[i],
                  {beat_addr[i], sc[s].w[i], ~i[0], i[0]});
         check($sformatf("s%0d_nsteps", s), steps.size(), sc[s].nsteps);
         for (int i = 0; i < steps.size() && i < sc[s].nsteps; i++)
            check($sformatf("s%0d_step%0d", s, i), steps[i], sc[s].first + i * sc[s].gap);
         cyc(); #1;
         check($sformatf("s%0d_underrun", s), underrun, 1);
`ifdef PSEQ_CLEAR_ON_IDLE_EN
         for (int i = 0; i < 8; i++) begin
            if (i > 0) begin cyc(); #1; end
            check("clear_beat", {busy, param_addr, param_in, param_write_lo, param_write_hi},
                  {1'b1, beat_addr[i], 32'd0, ~i[0], i[0]});
         end
         cyc(); #1;
`endif
         check($sformatf("s%0d_idle_after", s), {busy, param_write_lo, param_write_hi, acc_step}, 0);
      end

      // Back-to-back descriptors, period 5, dur 2
      cyc(); drive(32'h100, 32'd1, 32'd2, 32'd3, 16'd5, 32'd2); #1;
      cyc(); drive(32'h200, 32'd4, 32'd5, 32'd6, 16'd5, 32'd2); #1;
      check("b2b_ready_pend_empty", seg_ready, 1);
      check("b2b_underrun_cleared", underrun, 0);
      cyc(); seg_valid = 1'b0; #1;
      check("b2b_ready_pend_full", seg_ready, 0);
      done_off = -1;
      for (int off = 2; off <= 60; off++) begin
         if (off > 2) begin cyc(); #1; end
         if (seg_done) begin done_off = off; break; end
      end
      check("b2b_done1_cycle", done_off, 20);
      check("b2b_ready_at_done1", seg_ready, 0);
      check("b2b_no_underrun_done1", underrun, 0);
      cyc(); #1;
      check("b2b_load2_start", {busy, param_addr, param_in, param_write_lo, param_write_hi},
            {1'b1, 8'h00, 32'h200, 1'b1, 1'b0});
      check("b2b_ready_after_move", seg_ready, 1);
      check("b2b_underrun_mid", underrun, 0);
      done_off = -1;
      for (int off = 21; off <= 80; off++) begin
         if (off > 21) begin cyc(); #1; end
         if (seg_done) begin done_off = off; break; end
      end
      check("b2b_done2_cycle", done_off, 40);
      cyc(); #1;
      check("b2b_underrun_final", underrun, 1);

      // Asynchronous reset clears sticky underrun
      #2 rst_n = 1'b0;
      #1 check("reset_clears_underrun", {underrun, busy}, 0);
      @(negedge clk); rst_n = 1'b1;

      // Descriptor offered in the segment-end cycle
      cyc(); drive(32'h33, 32'd0, 32'd0, 32'd0, 16'd1, 32'd1); #1;
      cyc(); seg_valid = 1'b0; #1;
      for (int off = 2; off <= 10; off++) cyc();
      cyc(); drive(32'h44, 32'd0, 32'd0, 32'd0, 16'd1, 32'd1); #1;
      check("same_cycle_done", {seg_done, seg_ready}, 2'b11);
      cyc(); seg_valid = 1'b0; #1;
      check("same_cycle_no_underrun", underrun, 0);
      check("same_cycle_load", {busy, param_addr, param_in, param_write_lo, param_write_hi},
            {1'b1, 8'h00, 32'h44, 1'b1, 1'b0});
      cyc(); abort = 1'b1; #1;
      cyc(); abort = 1'b0; #1;
      check("abort_load_k1_idle", {busy, param_write_lo, param_write_hi}, 0);

      // Abort at LOAD k=3 with a pending descriptor
      cyc(); drive(32'd11, 32'd22, 32'd33, 32'd44, 16'd2, 32'd5); #1;
      cyc(); drive(32'd55, 32'd66, 32'd77, 32'd88, 16'd2, 32'd5); #1;
      check("abort_ld_pend_accept", seg_ready, 1);
      cyc(); seg_valid = 1'b0; #1;
      cyc(); #1;
      cyc(); abort = 1'b1; #1;
      check("abort_ld_ready_low", seg_ready, 0);
      check("abort_ld_k3_beat", {param_addr, param_in, param_write_lo, param_write_hi},
            {8'h03, 32'd0, 1'b0, 1'b1});
      check("abort_ld_no_done", seg_done, 0);
      cyc(); abort = 1'b0; #1;
      check("abort_ld_next", {busy, param_write_lo, param_write_hi, acc_step, seg_ready}, 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(); #1;
         if (busy || seg_done || param_write_lo || param_write_hi) cnt++;
      end
      check("abort_ld_pending_dropped", cnt, 0);

      // Abort mid-RUN
      cyc(); drive(32'd1, 32'd2, 32'd3, 32'd4, 16'd2, 32'd5); #1;
      cyc(); seg_valid = 1'b0; #1;
      for (int off = 2; off <= 11; off++) cyc();
      #1;
      check("abort_run_step11", {acc_step, underrun}, 2'b10);
      cyc(); abort = 1'b1; #1;
      check("abort_run_no_done", seg_done, 0);
      cyc(); abort = 1'b0; #1;
      check("abort_run_next", {busy, acc_step, seg_done}, 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); #1;
         if (busy || acc_step || seg_done) cnt++;
      end
      check("abort_run_quiet", cnt, 0);
      check("abort_run_underrun", underrun, 0);

      // Async reset pulse mid-RUN between edges
      cyc(); drive(32'd9, 32'd9, 32'd9, 32'd9, 16'd1, 32'd10); #1;
      cyc(); seg_valid = 1'b0; #1;
      for (int off = 2; off <= 12; off++) cyc();
      #1;
      check("rst_run_pre_step", {busy, acc_step}, 2'b11);
      #2 rst_n = 1'b0;
      #1 check("rst_run_outputs", {param_addr, param_in, param_write_lo, param_write_hi,
                                   acc_step, busy, seg_done, underrun}, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(); #1;
         if (busy || acc_step || seg_done) cnt++;
      end
      check("rst_run_quiet", cnt, 0);
      check("rst_run_ready", seg_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/profile_seq.md
PROFILE_SEQ -- requirements
Module: profile_seq

Interface
REQ-001 Parameter ADDR0, default 8'h00, profile_gen param address for descriptor word p0.
REQ-002 Parameter ADDR1, default 8'h03, param address for p1.
REQ-003 Parameter ADDR2, default 8'h04, param address for p2.
REQ-004 Parameter ADDR3, default 8'h05, param address for p3.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 seg_valid  input  1  descriptor offered.
REQ-008 seg_ready  output  1  descriptor accepted when seg_valid && seg_ready at a clock edge.
REQ-009 seg_p0, seg_p1, seg_p2, seg_p3  input  32 each  signed parameter words.
REQ-010 seg_period  input  16  clocks between acc_step pulses; 0 treated as 1.
REQ-011 seg_dur  input  32  number of acc_step pulses in the segment.
REQ-012 abort  input  1  synchronous stop.
REQ-013 param_addr  output  8; param_in  output  32; param_write_lo  output  1; param_write_hi  output  1  profile_gen write port.
REQ-014 acc_step  output  1  one-cycle step strobe to profile_gen.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 seg_done  output  1  one-cycle pulse per completed segment.
REQ-017 underrun  output  1  sticky flag.

Function
REQ-018 States IDLE, LOAD, RUN, plus CLEAR when PSEQ_CLEAR_ON_IDLE_EN is defined.
REQ-019 Descriptor storage: one active register plus one pending register; seg_ready = !pending_full && !abort.
REQ-020 Acceptance in IDLE loads active and enters LOAD next cycle; acceptance in LOAD/RUN fills pending.
REQ-021 LOAD lasts exactly 8 cycles, k=0..7: param_addr = ADDR(k/2); even k: param_in = p(k/2), write_lo=1, write_hi=0; odd k: param_in = 32 copies of bit 31 of p(k/2), write_hi=1, write_lo=0.
REQ-022 Outside LOAD/CLEAR: param_addr=0, param_in=0, both write strobes 0.
REQ-023 RUN: period counter loaded with max(seg_period,1) on entry; acc_step asserted for one cycle when the counter expires, then the counter reloads; the first acc_step occurs period cycles after RUN entry.
REQ-024 A 32-bit step counter counts acc_step pulses; the cycle after the pulse that makes it equal seg_dur, seg_done pulses and the state leaves RUN.
REQ-025 seg_dur=0: no acc_step; seg_done pulses the cycle after LOAD completes.
REQ-026 On segment end with pending full: pending moves to active, LOAD begins next cycle, no idle gap.
REQ-027 On segment end with pending empty: underrun set to 1, transition to CLEAR (macro defined) or IDLE.
REQ-028 A descriptor offered in the same cycle as segment end with pending empty is accepted into active and sets no underrun.
REQ-029 abort: next state IDLE, pending dropped, strobes and acc_step deasserted next cycle, no seg_done; a partially completed LOAD is not rolled back.
REQ-030 underrun clears only on reset or on acceptance of a descriptor in IDLE.

Reset
REQ-031 rst_n low asynchronously forces IDLE, clears active/pending, counters, param_addr, param_in, write strobes, acc_step, busy, seg_done, underrun to 0; seg_ready reads 1 after release.
REQ-032 Reset mid-LOAD or mid-RUN aborts with no further writes or steps.

Configuration
REQ-033 Macro PSEQ_CLEAR_ON_IDLE_EN defined: CLEAR state performs the 8-write LOAD sequence with all data 0, then IDLE; busy high and seg_ready follows REQ-019 during CLEAR; a descriptor accepted during CLEAR waits in pending and starts LOAD after CLEAR.
REQ-034 Macro undefined: no CLEAR state; profile_gen parameters keep last loaded values in IDLE.

Verification
REQ-035 Reset, one descriptor p0=1,p1=3,p2=4,p3=5, period=100, dur=3 -> 8 writes to 0/0/3/3/4/4/5/5 (lo=1,0xFFFF_FFFF? no: hi=0), acc_step at RUN+100,+200,+300, seg_done once, underrun=1.
REQ-036 p1=-2 -> hi write at ADDR1 carries 0xFFFF_FFFF, lo carries 0xFFFF_FFFE.
REQ-037 Two descriptors back-to-back (dur=2, period=5) -> second LOAD starts the cycle after first seg_done; seg_ready low while pending full; underrun only after second.
REQ-038 period=0, dur=4 -> acc_step high 4 consecutive cycles.
REQ-039 abort at LOAD k=3 and at mid-RUN -> IDLE next cycle, no seg_done, pending dropped; with macro defined, CLEAR writes eight zeros after final segment.
REQ-040 rst_n pulsed low mid-RUN between clock edges -> all outputs 0 immediately, no further acc_step.
